// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared constants and state encoding for the RLE blocks
// Purpose: default symbol/count widths and the run FSM state type, used by
//          rle_decompressor and rle_compressor.
// Ports:   none (package).
package rle_pkg;

   localparam int RLE_DATA_W = 8;
   localparam int RLE_CNT_W  = 8;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } rle_state_t;

endpackage

// File: rtl/rle_decompressor.sv
// rtl/rle_decompressor.sv - expands (symbol, count) pairs into a symbol stream
// Purpose: accepts a (data_in, count_in) pair and emits data_in count_in times
//          on a valid/ready output, back-to-back across runs, zero counts dropped.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   data_in, count_in     incoming pair
//   valid_in / ready_in   input handshake
//   data_out              expanded symbol
//   valid_out / ready_out output handshake
//   busy                  high while a run is being expanded
module rle_decompressor
   import rle_pkg::*;
#(
   parameter int DATA_W = RLE_DATA_W,
   parameter int CNT_W  = RLE_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic [CNT_W-1:0]  count_in,
   input  logic              valid_in,
   output logic              ready_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   input  logic              ready_out,
   output logic              busy
);

   rle_state_t        r_state;
   rle_state_t        w_next_state;
   logic [DATA_W-1:0] r_sym;
   logic [DATA_W-1:0] w_next_sym;
   logic [CNT_W-1:0]  r_remaining;
   logic [CNT_W-1:0]  w_next_remaining;

   logic w_last_beat;
   logic w_accept;
   logic w_consume;
   logic w_load;

   assign w_last_beat = (r_remaining == CNT_W'(1));

   // In EXPAND a new pair is only taken on the final beat being consumed,
   // so the reload lands exactly when the current run ends.
   assign ready_in  = (r_state == IDLE) ? 1'b1 : (w_last_beat && ready_out);
   assign valid_out = (r_state == EXPAND);
   assign data_out  = r_sym;
   assign busy      = (r_state == EXPAND);

   assign w_accept  = valid_in && ready_in;
   assign w_consume = valid_out && ready_out;
   assign w_load    = w_accept && (count_in != '0);

   always_comb begin
      w_next_state     = r_state;
      w_next_sym       = r_sym;
      w_next_remaining = r_remaining;
      case (r_state)
         IDLE: begin
            if (w_load) begin
               w_next_sym       = data_in;
               w_next_remaining = count_in;
               w_next_state     = EXPAND;
            end
         end
         EXPAND: begin
            if (w_consume) begin
               if (w_last_beat) begin
                  if (w_load) begin
                     w_next_sym       = data_in;
                     w_next_remaining = count_in;
                  end else begin
                     w_next_remaining = '0;
                     w_next_state     = IDLE;
                  end
               end else begin
                  w_next_remaining = r_remaining - CNT_W'(1);
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_sym       <= '0;
         r_remaining <= '0;
      end else begin
         r_state     <= w_next_state;
         r_sym       <= w_next_sym;
         r_remaining <= w_next_remaining;
      end
   end

endmodule
